// File: rtl/fwd_stall_unit.sv
// Operand forwarding, load-use/multdiv hazard stalls and multdiv watchdog FSM.
// Optional bex status forwarding is enabled by defining FWD_STALL_RSTATUS_EN.
module fwd_stall_unit #(
    parameter int REG_AW     = 5,
    parameter int MD_MAX_CYC = 40,
    parameter int CNT_W      = 6
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [REG_AW-1:0] i_dx_rs1,
    input  logic [REG_AW-1:0] i_dx_rs2,
    input  logic              i_dx_use_rs1,
    input  logic              i_dx_use_rs2,
    input  logic [REG_AW-1:0] i_dx_rd,
    input  logic              i_dx_is_md,
    input  logic [REG_AW-1:0] i_xm_rd,
    input  logic              i_xm_wen,
    input  logic              i_xm_is_load,
    input  logic              i_xm_excep,
    input  logic [REG_AW-1:0] i_mw_rd,
    input  logic              i_mw_wen,
    input  logic              i_mw_excep,
    input  logic              i_md_ready,
    input  logic              i_dx_is_bex,
    input  logic              i_xm_is_setx,
    input  logic              i_mw_is_setx,
    output logic [1:0]        o_fwd_a,
    output logic [1:0]        o_fwd_b,
    output logic              o_mem_fwd,
    output logic [1:0]        o_bex_sel,
    output logic              o_stall,
    output logic              o_md_busy,
    output logic              o_md_wb,
    output logic              o_md_timeout,
    output logic [REG_AW-1:0] o_md_rd
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [REG_AW-1:0] r_md_rd;
    logic              r_md_busy;
    logic              r_md_wb;

    function automatic logic f_match(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rd,
        input logic              wen
    );
        return (rs == rd) && wen && (rd != '0);
    endfunction

    logic w_xm_a, w_mw_a, w_xm_b, w_mw_b;
    logic w_lu_stall, w_md_stall, w_bex_stall;
    logic w_md_hit1, w_md_hit2, w_wd_expire;

    assign w_xm_a = i_dx_use_rs1 && f_match(i_dx_rs1, i_xm_rd, i_xm_wen) && !i_xm_excep;
    assign w_mw_a = i_dx_use_rs1 && f_match(i_dx_rs1, i_mw_rd, i_mw_wen) && !i_mw_excep;
    assign w_xm_b = i_dx_use_rs2 && f_match(i_dx_rs2, i_xm_rd, i_xm_wen) && !i_xm_excep;
    assign w_mw_b = i_dx_use_rs2 && f_match(i_dx_rs2, i_mw_rd, i_mw_wen) && !i_mw_excep;

    assign o_fwd_a = w_xm_a ? 2'b01 : (w_mw_a ? 2'b10 : 2'b00);
    assign o_fwd_b = w_xm_b ? 2'b01 : (w_mw_b ? 2'b10 : 2'b00);

    assign o_mem_fwd = (i_xm_rd == i_mw_rd) && i_mw_wen &&
                       (i_mw_rd != '0) && !i_mw_excep;

    assign w_lu_stall = i_xm_is_load &&
        ((i_dx_use_rs1 && f_match(i_dx_rs1, i_xm_rd, i_xm_wen)) ||
         (i_dx_use_rs2 && f_match(i_dx_rs2, i_xm_rd, i_xm_wen)));

    assign w_md_hit1  = i_dx_use_rs1 && (i_dx_rs1 == r_md_rd) && (r_md_rd != '0);
    assign w_md_hit2  = i_dx_use_rs2 && (i_dx_rs2 == r_md_rd) && (r_md_rd != '0);
    assign w_md_stall = r_md_busy && (w_md_hit1 || w_md_hit2 || i_dx_is_md);

`ifdef FWD_STALL_RSTATUS_EN
    assign o_bex_sel   = (i_dx_is_bex && i_xm_is_setx) ? 2'b01 :
                         (i_dx_is_bex && i_mw_is_setx) ? 2'b10 : 2'b00;
    assign w_bex_stall = 1'b0;
`else
    // No status bypass path: a bex right behind a setx must wait a cycle.
    logic w_unused_mw_setx;
    assign w_unused_mw_setx = i_mw_is_setx;
    assign o_bex_sel   = 2'b00;
    assign w_bex_stall = i_dx_is_bex && i_xm_is_setx;
`endif

    // DONE holds the pipe because the multdiv result owns the writeback port.
    assign o_stall = w_lu_stall || w_md_stall || w_bex_stall || (r_state == S_DONE);

    // A late md_ready on the final watchdog cycle still wins.
    assign w_wd_expire = (r_state == S_BUSY) && !i_md_ready &&
                         (r_cnt == CNT_W'(MD_MAX_CYC - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_md_rd   <= '0;
            r_md_busy <= 1'b0;
            r_md_wb   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (i_dx_is_md && !o_stall) begin
                        r_state   <= S_BUSY;
                        r_md_rd   <= i_dx_rd;
                        r_cnt     <= '0;
                        r_md_busy <= 1'b1;
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (i_md_ready) begin
                        r_state <= S_DONE;
                        r_md_wb <= 1'b1;
                    end else if (w_wd_expire) begin
                        r_state   <= S_IDLE;
                        r_md_busy <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state   <= S_IDLE;
                    r_md_busy <= 1'b0;
                    r_md_wb   <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_md_busy <= 1'b0;
                    r_md_wb   <= 1'b0;
                end
            endcase
        end
    end

    assign o_md_busy    = r_md_busy;
    assign o_md_wb      = r_md_wb;
    assign o_md_timeout = w_wd_expire;
    assign o_md_rd      = r_md_rd;

endmodule
